// File: rtl/debouncer_multi.sv
// Multi-channel integrating debouncer: synchronise, integrate on a shared tick,
// and drive registered levels with hysteresis plus one-cycle edge pulses.
module debouncer_multi #(
  parameter int                  CHANNELS    = 8,
  parameter int                  WIDTH       = 16,
  parameter int                  DIVIDER     = 1,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] INVERT      = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIVIDER - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick;
  logic [CHANNELS-1:0] s;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);
  assign s     = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Each counter saturates at both bounds; the level only flips at a bound.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick) begin
        if (s[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else if (!s[i] && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
      if (cnt_d[i] == CNT_MAX) begin
        dout_d[i] = 1'b1;
      end else if (cnt_d[i] == '0) begin
        dout_d[i] = 1'b0;
      end
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      pre_q  <= '0;
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pre_q  <= pre_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench: two debouncer instances (plain, and divided/inverted) share
// stimulus; a cycle-level integrator model predicts every registered output.
module tb_debouncer_multi;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DIVS [2] = '{1, 3};
  localparam logic [CH-1:0] INVS [2] = '{4'b0000, 4'b0010};

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [CH-1:0] doutA, riseA, fallA;
  logic [CH-1:0] doutB, riseB, fallB;
  logic          changedA, changedB;

  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;
  exp_t expQ[$];

  // Reference model state
  logic [CH-1:0] hist[$];
  int            edgeN;
  int            mCnt  [2][CH];
  logic [CH-1:0] mDout [2];
  logic [CH-1:0] mRise [2];
  logic [CH-1:0] mFall [2];

  debouncer_multi #(.CHANNELS(CH), .WIDTH(W), .DIVIDER(1), .SYNC_STAGES(SS),
                    .INVERT(4'b0000)) dutA (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(doutA), .rise(riseA), .fall(fallA), .changed(changedA));

  debouncer_multi #(.CHANNELS(CH), .WIDTH(W), .DIVIDER(3), .SYNC_STAGES(SS),
                    .INVERT(4'b0010)) dutB (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(doutB), .rise(riseB), .fall(fallB), .changed(changedB));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (changed,fall,rise,dout) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    edgeN = 0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < CH; c++) mCnt[n][c] = 0;
      mDout[n] = '0;
      mRise[n] = '0;
      mFall[n] = '0;
    end
  endtask

  // Predict the outputs right after the coming rising edge.
  task automatic modelStep();
    exp_t e;
    logic [CH-1:0] s;
    logic [CH-1:0] old;
    bit tick;
    if (!rst_n) begin
      modelReset();
    end else begin
      edgeN++;
      hist.push_back(din);
      for (int n = 0; n < 2; n++) begin
        s = (hist.size() > SS) ? hist[hist.size()-1-SS] : '0;
        s = s ^ INVS[n];
        tick = ((edgeN - 1) % DIVS[n]) == (DIVS[n] - 1);
        old = mDout[n];
        for (int c = 0; c < CH; c++) begin
          if (tick) mCnt[n][c] = s[c] ? ((mCnt[n][c] < W) ? mCnt[n][c] + 1 : W)
                                      : ((mCnt[n][c] > 0) ? mCnt[n][c] - 1 : 0);
          if (mCnt[n][c] == W) mDout[n][c] = 1'b1;
          else if (mCnt[n][c] == 0) mDout[n][c] = 1'b0;
        end
        mRise[n] = mDout[n] & ~old;
        mFall[n] = ~mDout[n] & old;
      end
    end
    e.a = {|(mRise[0] | mFall[0]), mFall[0], mRise[0], mDout[0]};
    e.b = {|(mRise[1] | mFall[1]), mFall[1], mRise[1], mDout[1]};
    expQ.push_back(e);
  endtask

  // One cycle of stimulus; a falling rst_n is applied between edges and its
  // asynchronous effect checked before the next rising edge.
  task automatic applyStimulus(input logic [CH-1:0] d, input logic rstn, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (!rstn && rst_n) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetA", {changedA, fallA, riseA, doutA}, 13'h0);
        checkOutput("asyncResetB", {changedB, fallB, riseB, doutB}, 13'h0);
      end
      rst_n = rstn;
      din   = d;
      modelStep();
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", 13'h1, 13'h0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("instA", {changedA, fallA, riseA, doutA}, e.a);
        checkOutput("instB", {changedB, fallB, riseB, doutB}, e.b);
      end
    end
  end

  initial begin
    logic [CH-1:0] r;
    rst_n = 1'b0;
    din   = '0;
    modelReset();
    #1;
    checkOutput("resetA", {changedA, fallA, riseA, doutA}, 13'h0);
    checkOutput("resetB", {changedB, fallB, riseB, doutB}, 13'h0);

    applyStimulus(4'b0000, 1'b0, 3);
    applyStimulus(4'b0001, 1'b1, 10);
    applyStimulus(4'b0000, 1'b1, 3);
    applyStimulus(4'b0001, 1'b1, 8);
    applyStimulus(4'b0000, 1'b1, 10);
    applyStimulus(4'b0100, 1'b1, 20);
    applyStimulus(4'b1011, 1'b1, 16);
    applyStimulus(4'b0000, 1'b1, 16);
    applyStimulus(4'b0001, 1'b1, 8);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0001, 1'b1, 2);
    applyStimulus(4'b0001, 1'b0, 2);
    applyStimulus(4'b0001, 1'b1, 10);

    for (int k = 0; k < 60; k++) begin
      r = CH'($urandom);
      if ($urandom_range(0, 24) == 0) applyStimulus(r, 1'b0, $urandom_range(1, 3));
      applyStimulus(r, 1'b1, $urandom_range(1, 16));
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    if (expQ.size() != 0) checkOutput("scoreboardDrain", 13'(expQ.size()), 13'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent input channels.
REQ-002 SHALL have parameter WIDTH, default 16: integrator threshold in ticks, range 1..65535.
REQ-003 SHALL have parameter DIVIDER, default 1: clock cycles per integrator tick, range 1..65535.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..4.
REQ-005 SHALL have parameter INVERT, default 0, CHANNELS bits: per-channel input polarity inversion mask.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-008 SHALL have port din, input, CHANNELS: raw asynchronous inputs.
REQ-009 SHALL have port dout, output, CHANNELS: debounced levels, registered.
REQ-010 SHALL have port rise, output, CHANNELS: one-cycle pulse per channel on each dout 0->1 transition, registered.
REQ-011 SHALL have port fall, output, CHANNELS: one-cycle pulse per channel on each dout 1->0 transition, registered.
REQ-012 SHALL have port changed, output, 1: OR of all rise and fall bits, combinational from registered bits.

Function
REQ-013 SHALL pass each din bit through a SYNC_STAGES flip-flop chain; sampled value s[i] = last stage XOR INVERT[i].
REQ-014 SHALL run one shared prescaler counting 0..DIVIDER-1 and wrapping to 0; tick asserts in the cycle the prescaler equals DIVIDER-1; DIVIDER=1 gives a tick every cycle.
REQ-015 SHALL keep one saturating counter per channel, width clog2(WIDTH+1), range 0..WIDTH.
REQ-016 On tick: s[i]=1 and cnt<WIDTH -> cnt+1; s[i]=0 and cnt>0 -> cnt-1; otherwise hold; no wrap at either bound.
REQ-017 Without tick: every counter SHALL hold.
REQ-018 dout[i] SHALL be set on the edge at which cnt_next equals WIDTH and cleared on the edge at which cnt_next equals 0; otherwise hold (hysteresis).
REQ-019 rise[i]/fall[i] SHALL assert on the same edge that dout[i] changes and deassert on the next edge; never both asserted together.
REQ-020 Latency from a stable din change to dout: SYNC_STAGES cycles plus WIDTH ticks, when cnt starts at the opposite bound.
REQ-021 A glitch of k ticks with k < WIDTH, on a channel at a bound, SHALL NOT change dout.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses.

Reset
REQ-023 rst_n low SHALL immediately, without a clock edge, force to 0: synchroniser flops, prescaler, all counters, dout, rise, fall and changed.
REQ-024 After reset a channel with INVERT[i]=1 SHALL see s[i]=1 and count up from the first edge after rst_n deasserts.
REQ-025 Reset asserted mid-count SHALL discard partial counts; no pulse SHALL be emitted on reset entry or exit.

Verification (CHANNELS=4, WIDTH=4, DIVIDER=1, SYNC_STAGES=2, INVERT=0 unless stated)
REQ-026 din=4'b0001 from reset release -> dout[0]=1 and rise[0]=1 after edge 6, rise[0]=0 after edge 7; other bits stay 0; changed pulses once.
REQ-027 dout[0]=1 settled, din[0] low for 3 cycles then high -> dout[0] stays 1, no fall pulse (cnt 4->1->4).
REQ-028 dout[0]=1 settled, din[0] low held -> dout[0]=0 and fall[0]=1 on the 6th edge after the change.
REQ-029 DIVIDER=3, din[2] rises and is held -> dout[2] rises 2 + 12 cycles later, with phase tolerance of at most 2 cycles.
REQ-030 INVERT=4'b0010, din=0 -> dout[1]=1 with rise[1] pulse after edge 4 post-reset; other channels 0.
REQ-031 Assert rst_n low between clock edges with cnt=3 and dout=1 -> all outputs 0 before the next edge; after release, full 6-cycle latency applies again.
